iopad_bank: RTL

Parametrised N-channel I/O pad bank: the multi-channel, configurable successor to the single-channel `iopad`. It sits between the FPGA fabric and the chip pads. Each channel has 3 configuration bits loaded through the OpenFPGA-style configuration chain. Per channel it provides an input synchroniser, an optional glitch filter, and four output modes (input-only, direct output, registered output, fabric-controlled bidirectional).

---
 rtl/iopad_bank_if.sv | 13 +
 rtl/iopad_bank.sv | 57 +++++
 2 files changed

// File: rtl/iopad_bank_if.sv
// iopad_bank_if: config chain, fabric and pad signals of an iopad_bank
interface iopad_bank_if #(parameter int NUM_IO = 8);
  logic ccff_head, ccff_tail, cfg_en;
  logic [NUM_IO-1:0] fab_out, fab_oe, fab_in, pad_in, pad_out, pad_oe;
  modport master (
    output ccff_head, cfg_en, fab_out, fab_oe, pad_in,
    input  ccff_tail, fab_in, pad_out, pad_oe
  );
  modport slave (
    input  ccff_head, cfg_en, fab_out, fab_oe, pad_in,
    output ccff_tail, fab_in, pad_out, pad_oe
  );
endinterface

// File: rtl/iopad_bank.sv
// iopad_bank: N-channel configurable pad bank; define IOPAD_BANK_FILTER_EN to build the input glitch filter
module iopad_bank #(
  parameter int NUM_IO = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W = 4
) (
  input logic CLK,
  input logic RESET,
  iopad_bank_if.slave io
);
  localparam int cw = 3 * NUM_IO;
  logic [cw-1:0] cfg;
  logic [NUM_IO-1:0] sync [SYNC_STAGES];
  logic [NUM_IO-1:0] sync_out, out_q, in_q;
  assign sync_out = sync[SYNC_STAGES-1];
  assign io.ccff_tail = cfg[cw-1];
  assign io.fab_in = in_q;
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      cfg <= '0;
      out_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
    end else begin
      if (io.cfg_en) cfg <= {cfg[cw-2:0], io.ccff_head};
      out_q <= io.fab_out;
      sync[0] <= io.pad_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
`ifdef IOPAD_BANK_FILTER_EN
  localparam logic [FILT_W-1:0] cnt_top = FILT_W'((2 ** FILT_W) - 2);
  logic [FILT_W-1:0] cnt [NUM_IO];
  // unfiltered channels and accepted changes both reload in_q and clear the count
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      in_q <= '0;
      for (int k = 0; k < NUM_IO; k++) cnt[k] <= '0;
    end else if (!io.cfg_en)
      for (int k = 0; k < NUM_IO; k++)
        if (!cfg[3*k+2] || (sync_out[k] != in_q[k] && cnt[k] == cnt_top)) begin
          in_q[k] <= sync_out[k];
          cnt[k] <= '0;
        end else
          cnt[k] <= (sync_out[k] != in_q[k]) ? cnt[k] + 1'b1 : '0;
`else
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) in_q <= '0;
    else if (!io.cfg_en) in_q <= sync_out;
`endif
  always_comb begin
    io.pad_out = '0;
    io.pad_oe = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      io.pad_out[k] = (cfg[3*k +: 2] == 2'b10) ? out_q[k] : (cfg[3*k +: 2] != 2'b00) & io.fab_out[k];
      io.pad_oe[k] = !io.cfg_en & ((cfg[3*k +: 2] == 2'b11) ? io.fab_oe[k] : (cfg[3*k +: 2] != 2'b00));
    end
  end
endmodule
